// File: rtl/conv_kxk_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv_kxk_stream
// Function : Streaming KxK signed convolution (stride 1, no padding) over a
//            raster-order image, with bias, symmetric saturation and ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module conv_kxk_stream #(
    parameter int DW    = 16,
    parameter int OW    = 32,
    parameter int K     = 5,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int AW    = $clog2(K*K)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iValid,
    input  logic signed [DW-1:0] iX,
    input  logic                 iWren,
    input  logic [AW-1:0]        iADDR,
    input  logic signed [DW-1:0] iW,
    input  logic                 iBiasWr,
    input  logic signed [OW-1:0] iBias,
    input  logic                 iRelu,
    input  logic                 iFlush,
    output logic signed [OW-1:0] oY,
    output logic                 oValid,
    output logic                 oLast,
    output logic                 oBusy
);

    localparam int c_NT = K*K;
    localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_PW = 2*DW;
    localparam int c_SW = 2*DW + $clog2(K*K) + 1;
    localparam int c_BW = ((c_SW > OW) ? c_SW : OW) + 1;
    localparam logic signed [c_BW-1:0] c_MAX   = {{(c_BW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [c_BW-1:0] c_MIN   = -c_MAX;
    localparam logic signed [OW-1:0]   c_MAX_O = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0]   c_MIN_O = {1'b1, {(OW-2){1'b0}}, 1'b1};

    logic [c_CW-1:0]        r_col;
    logic [c_RW-1:0]        r_row;
    logic signed [DW-1:0]   r_w     [c_NT];
    logic signed [OW-1:0]   r_bias;
    logic signed [DW-1:0]   r_win   [c_NT];
    logic signed [c_PW-1:0] r_prod  [c_NT];
    logic signed [c_SW-1:0] r_sum;
    logic                   r_v1, r_v2, r_l1, r_l2, r_relu1, r_relu2;

    logic                   w_acc, w_col_end, w_row_end, w_complete, w_idle, w_addr_ok;
    logic signed [DW-1:0]   w_lb_rd    [K-1];
    logic signed [DW-1:0]   w_col_vec  [K];
    logic signed [DW-1:0]   w_win_next [c_NT];
    logic signed [c_SW-1:0] w_sum;
    logic signed [c_BW-1:0] w_tot;
    logic signed [OW-1:0]   w_res;

    assign w_acc      = iValid && !iFlush;
    assign w_col_end  = (r_col == c_CW'(IMG_W-1));
    assign w_row_end  = (r_row == c_RW'(IMG_H-1));
    assign w_complete = w_acc && (r_row >= c_RW'(K-1)) && (r_col >= c_CW'(K-1));
    assign oBusy      = (r_col != '0) || (r_row != '0);
    assign w_idle     = !oBusy && !r_v1 && !r_v2 && !oValid && !iFlush;
    assign w_addr_ok  = ({1'b0, iADDR} < (AW+1)'(c_NT));

    always_ff @(posedge iCLK) begin
        if (iRST || iFlush) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Coefficients only change when no window is being computed with them.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < c_NT; i++) r_w[i] <= '0;
            r_bias <= '0;
        end else if (w_idle) begin
            if (iWren && w_addr_ok) r_w[iADDR] <= iW;
            if (iBiasWr)            r_bias     <= iBias;
        end
    end

    // Line buffer i holds the row (i+1) above the current one, at each column.
    generate
        for (genvar gi = 0; gi < K-1; gi++) begin : g_lb
            logic signed [DW-1:0] r_mem [IMG_W];
            always_ff @(posedge iCLK) begin
                if (w_acc) r_mem[r_col] <= w_col_vec[K-1-gi];
            end
            assign w_lb_rd[gi] = r_mem[r_col];
        end
    endgenerate

    always_comb begin
        w_col_vec[K-1] = iX;
        for (int i = 0; i < K-1; i++) w_col_vec[K-2-i] = w_lb_rd[i];
    end

    // Next window is used directly so products register on the completing beat.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) w_win_next[r*K+c] = r_win[r*K+c+1];
            w_win_next[r*K+K-1] = w_col_vec[r];
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_acc) r_win <= w_win_next;
        if (w_complete) begin
            for (int i = 0; i < c_NT; i++) r_prod[i] <= c_PW'(w_win_next[i]) * c_PW'(r_w[i]);
        end
        r_sum <= w_sum;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_NT; i++) begin
            w_sum = w_sum + {{(c_SW-c_PW){r_prod[i][c_PW-1]}}, r_prod[i]};
        end
    end

    always_comb begin
        w_tot = {{(c_BW-c_SW){r_sum[c_SW-1]}}, r_sum} + {{(c_BW-OW){r_bias[OW-1]}}, r_bias};
        if (r_relu2 && w_tot[c_BW-1]) w_res = '0;
        else if (w_tot > c_MAX)       w_res = c_MAX_O;
        else if (w_tot < c_MIN)       w_res = c_MIN_O;
        else                          w_res = w_tot[OW-1:0];
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iFlush) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_l1    <= 1'b0;
            r_l2    <= 1'b0;
            r_relu1 <= 1'b0;
            r_relu2 <= 1'b0;
            oValid  <= 1'b0;
            oLast   <= 1'b0;
            oY      <= '0;
        end else begin
            r_v1    <= w_complete;
            r_l1    <= w_complete && w_col_end && w_row_end;
            r_relu1 <= iRelu;
            r_v2    <= r_v1;
            r_l2    <= r_l1;
            r_relu2 <= r_relu1;
            oValid  <= r_v2;
            oLast   <= r_v2 && r_l2;
            oY      <= r_v2 ? w_res : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_kxk_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_kxk_stream
// Function : Scoreboard bench for conv_kxk_stream with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_kxk_stream;

    localparam int DW = 16, OW = 32, K = 5, W = 32, H = 32, AW = 5, NT = 25;
    localparam int NOUT = (W-K+1)*(H-K+1);

    typedef struct {
        longint y;
        int     last;
        int     t;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 iRST, iValid, iWren, iBiasWr, iRelu, iFlush;
    logic signed [DW-1:0] iX, iW;
    logic [AW-1:0]        iADDR;
    logic signed [OW-1:0] iBias, oY;
    logic                 oValid, oLast, oBusy;

    int     cyc = 0, n_cmp = 0, n_bad = 0, n_out = 0;
    int     tr = 0, tc = 0, pmode = 0;
    bit     mon_en = 0, use_const = 0;
    longint pconst = 0, exp_const = 0, b_m = 0;
    longint w_m [NT];
    exp_t   sb [$];

    conv_kxk_stream #(.DW(DW), .OW(OW), .K(K), .IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .iCLK(clk), .iRST(iRST), .iValid(iValid), .iX(iX), .iWren(iWren), .iADDR(iADDR),
        .iW(iW), .iBiasWr(iBiasWr), .iBias(iBias), .iRelu(iRelu), .iFlush(iFlush),
        .oY(oY), .oValid(oValid), .oLast(oLast), .oBusy(oBusy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (oValid) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("y", $signed(oY), e.y);
                    chk("last", oLast, e.last);
                    chk("latency_cycle", cyc, e.t);
                end
            end else begin
                chk("idle_outputs_zero", (oY != 0 || oLast) ? 1 : 0, 0);
            end
        end
    end

    function automatic longint pix(input int r, input int c);
        if (pmode == 0) return pconst;
        return ((r*37 + c*101) % 2001) - 1000;
    endfunction

    function automatic longint model(input int r, input int c, input bit relu);
        longint s = b_m;
        for (int rr = 0; rr < K; rr++)
            for (int cc = 0; cc < K; cc++)
                s += w_m[rr*K+cc] * pix(r-K+1+rr, c-K+1+cc);
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483647) s = -64'sd2147483647;
        if (relu && s < 0)        s = 0;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit relu);
        iValid = 1'b1;
        iX     = DW'(pix(tr, tc));
        iRelu  = relu;
        if (tr >= K-1 && tc >= K-1) begin
            exp_t e;
            e.y    = use_const ? exp_const : model(tr, tc, relu);
            e.last = (tr == H-1 && tc == W-1) ? 1 : 0;
            e.t    = cyc + 3;
            sb.push_back(e);
        end
        if (tc == W-1) begin
            tc = 0;
            tr = (tr == H-1) ? 0 : tr + 1;
        end else begin
            tc++;
        end
        tick();
        iValid = 1'b0;
    endtask

    task automatic frame(input bit relu, input bit gap);
        n_out = 0;
        for (int i = 0; i < W*H; i++) begin
            beat(relu);
            if (gap) begin
                tick();
                tick();
            end
        end
    endtask

    task automatic drain(input bit count_chk);
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("queue_drained", sb.size(), 0);
        if (count_chk) chk("frame_output_count", n_out, NOUT);
    endtask

    task automatic wr_w(input int a, input longint v);
        iWren = 1'b1;
        iADDR = AW'(a);
        iW    = DW'(v);
        tick();
        iWren = 1'b0;
    endtask

    task automatic wr_all(input longint v);
        for (int i = 0; i < NT; i++) begin
            wr_w(i, v);
            w_m[i] = v;
        end
    endtask

    task automatic wr_b(input longint v);
        iBiasWr = 1'b1;
        iBias   = OW'(v);
        tick();
        iBiasWr = 1'b0;
    endtask

    task automatic const_frame(input longint p, input longint e, input bit relu);
        pmode = 0; pconst = p; use_const = 1; exp_const = e;
        frame(relu, 0);
        drain(1);
    endtask

    task automatic load_varied();
        for (int i = 0; i < NT; i++) begin
            wr_w(i, ((i*1237) % 4001) - 2000);
            w_m[i] = ((i*1237) % 4001) - 2000;
        end
        wr_b(-7);
        b_m = -7;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1; iValid = 0; iWren = 0; iBiasWr = 0; iRelu = 0; iFlush = 0;
        iX = '0; iW = '0; iADDR = '0; iBias = '0;
        for (int i = 0; i < NT; i++) w_m[i] = 0;
        tick();
        tick();
        chk("reset_oValid", oValid, 0);
        chk("reset_oY", $signed(oY), 0);
        chk("reset_oLast", oLast, 0);
        chk("reset_oBusy", oBusy, 0);
        iRST = 0;
        mon_en = 1;

        // All ones: 784 outputs of 25, first at beat 132 + 3 cycles.
        wr_all(1);
        const_frame(1, 25, 0);

        // Saturation at both ends.
        wr_all(32767);
        const_frame(32767, 2147483647, 0);
        const_frame(-32768, -2147483647, 0);

        // Negative result with and without ReLU, then bias.
        wr_all(-1);
        const_frame(1, -25, 0);
        const_frame(1, 0, 1);
        wr_b(30);
        b_m = 30;
        const_frame(1, 5, 1);

        // Varied image and weights, continuous then with 1,0,0 gaps.
        load_varied();
        pmode = 1; use_const = 0;
        frame(0, 0);
        drain(1);
        frame(0, 1);
        drain(1);

        // Reset mid-frame clears weights and bias.
        for (int i = 0; i < 500; i++) beat(0);
        iRST = 1;
        tick();
        iRST = 0;
        sb.delete();
        tr = 0; tc = 0;
        chk("rst_mid_oValid", oValid, 0);
        chk("rst_mid_oBusy", oBusy, 0);
        for (int i = 0; i < NT; i++) w_m[i] = 0;
        b_m = 0;
        const_frame(1, 0, 0);

        // Flush mid-frame keeps weights; the coincident pixel is dropped.
        load_varied();
        pmode = 1; use_const = 0;
        for (int i = 0; i < 500; i++) beat(0);
        iFlush = 1; iValid = 1; iX = 16'sd1234;
        tick();
        iFlush = 0; iValid = 0;
        sb.delete();
        tr = 0; tc = 0;
        chk("flush_oBusy", oBusy, 0);
        chk("flush_oValid", oValid, 0);
        frame(1, 0);
        drain(1);

        // Writes while busy, while in flight, out of range, or with flush are ignored.
        n_out = 0;
        for (int i = 0; i < W*H; i++) begin
            beat(0);
            if (i == 300) begin
                wr_w(3, 1111);
                wr_b(4444);
            end
        end
        wr_w(4, 2222);
        drain(1);
        wr_w(25, 3333);
        iFlush = 1;
        wr_w(0, 999);
        iFlush = 0;
        frame(0, 0);
        drain(1);

        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
